// File: rtl/result_display_sequencer.sv
// Walks a 4-digit multiplexed 7-segment display through a snapshot of the
// multiplier result entries, advancing on a dwell timer or on step pulses.
module result_display_sequencer #(
    parameter int REFRESH_DIV = 1000,
    parameter int DWELL_SCANS = 256,
    parameter int N_ELEM      = 4,
    localparam int IW         = $clog2(N_ELEM)
) (
    input  logic                  clkd,
    input  logic                  rst,
    input  logic [16*N_ELEM-1:0]  elem_data,
    input  logic                  load,
    input  logic                  clear,
    input  logic                  step,
    input  logic                  auto_mode,
    input  logic                  loop_en,
    input  logic                  lz_blank,
    output logic [3:0]            digit_sel,
    output logic [3:0]            nibble,
    output logic                  blank,
    output logic [IW-1:0]         elem_idx,
    output logic                  busy
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int FW = $clog2(DWELL_SCANS + 1);

    typedef enum logic [1:0] {IDLE, SHOW, HOLD} state_t;

    state_t                     state, state_nxt;
    logic [PW-1:0]              pre;
    logic [FW-1:0]              frames;
    logic [3:0]                 dsel;
    logic [IW-1:0]              idx;
    logic [N_ELEM-1:0][15:0]    shadow;

    logic       scan, pre_tc, frame_end, last, dwell_hit, advance;
    logic [1:0] dig;
    logic [15:0] rem;

    assign scan      = (state != IDLE);
    assign pre_tc    = (pre == PW'(REFRESH_DIV - 1));
    assign frame_end = scan && pre_tc && (dsel == 4'b0111);
    assign last      = (idx == IW'(N_ELEM - 1));
    // frame counter saturates one short of the dwell so a late switch to
    // auto mode advances at the next frame boundary
    assign dwell_hit = auto_mode && frame_end && (frames >= FW'(DWELL_SCANS - 1));
    assign advance   = (state == SHOW) && !clear && !load && (step || dwell_hit);

    always_ff @(posedge clkd) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear)                          state_nxt = IDLE;
        else if (load)                      state_nxt = SHOW;
        else if (advance && last && !loop_en) state_nxt = HOLD;
    end

    always_ff @(posedge clkd) begin
        if (rst) begin
            pre    <= '0;
            frames <= '0;
            dsel   <= 4'b1111;
            idx    <= '0;
            shadow <= '0;
        end else if (clear) begin
            pre    <= '0;
            frames <= '0;
            dsel   <= 4'b1111;
            idx    <= '0;
        end else if (load) begin
            shadow <= elem_data;
            pre    <= '0;
            frames <= '0;
            dsel   <= 4'b1110;
            idx    <= '0;
        end else if (scan) begin
            pre <= pre_tc ? '0 : pre + PW'(1);
            if (pre_tc) begin
                case (dsel)
                    4'b1110: dsel <= 4'b1101;
                    4'b1101: dsel <= 4'b1011;
                    4'b1011: dsel <= 4'b0111;
                    default: dsel <= 4'b1110;
                endcase
            end
            // scan phase is deliberately left running across an advance
            if (advance) begin
                frames <= '0;
                if (!last)       idx <= idx + IW'(1);
                else if (loop_en) idx <= '0;
            end else if (frame_end && (state == SHOW) && (frames < FW'(DWELL_SCANS - 1))) begin
                frames <= frames + FW'(1);
            end
        end
    end

    always_comb begin
        case (dsel)
            4'b1101: dig = 2'd1;
            4'b1011: dig = 2'd2;
            4'b0111: dig = 2'd3;
            default: dig = 2'd0;
        endcase
    end

    // rem holds nibbles dig..3, so it is zero exactly when this digit is a leading zero
    assign rem       = shadow[idx] >> {dig, 2'b00};
    assign nibble    = scan ? rem[3:0] : 4'h0;
    assign blank     = !scan || (lz_blank && (dig != 2'd0) && (rem == 16'h0));
    assign digit_sel = dsel;
    assign elem_idx  = idx;
    assign busy      = scan;
endmodule

// File: tb/tb_result_display_sequencer.sv
// Directed bench for result_display_sequencer with a queue scoreboard of
// expected per-cycle display outputs.
module tb_result_display_sequencer;
    localparam int RD = 4, DW = 2, NE = 4;

    logic        clkd = 1'b0;
    logic        rst, load, clear, step, auto_mode, loop_en, lz_blank;
    logic [63:0] elem_data;
    logic [3:0]  digit_sel, nibble;
    logic        blank, busy;
    logic [1:0]  elem_idx;

    result_display_sequencer #(.REFRESH_DIV(RD), .DWELL_SCANS(DW), .N_ELEM(NE)) dut (
        .clkd(clkd), .rst(rst), .elem_data(elem_data), .load(load), .clear(clear),
        .step(step), .auto_mode(auto_mode), .loop_en(loop_en), .lz_blank(lz_blank),
        .digit_sel(digit_sel), .nibble(nibble), .blank(blank), .elem_idx(elem_idx),
        .busy(busy)
    );

    always #5 clkd = ~clkd;

    typedef struct {
        logic [3:0] ds;
        logic [3:0] nib;
        logic       blk;
        logic [1:0] idx;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] ent[4];
    int          total = 0;
    int          bad   = 0;

    task automatic tick;
        @(posedge clkd);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic set_data;
        elem_data = {ent[3], ent[2], ent[1], ent[0]};
    endtask

    // k = cycles since the load that started the scan
    task automatic push_exp(input int k, input int idx, input logic lz);
        exp_t        e;
        int          d;
        logic [15:0] r;
        d     = (k / RD) % 4;
        r     = ent[idx] >> (4 * d);
        e.ds  = ~(4'b0001 << d);
        e.nib = r[3:0];
        e.blk = lz && (d > 0) && (r == 16'h0);
        e.idx = 2'(idx);
        sbq.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'd0, 16'd1);
            return;
        end
        e = sbq.pop_front();
        chk({tag, "_ds"},  16'(digit_sel), 16'(e.ds));
        chk({tag, "_nib"}, 16'(nibble),    16'(e.nib));
        chk({tag, "_blk"}, 16'(blank),     16'(e.blk));
        chk({tag, "_idx"}, 16'(elem_idx),  16'(e.idx));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ds"},   16'(digit_sel), 16'hf);
        chk({tag, "_nib"},  16'(nibble),    16'h0);
        chk({tag, "_blk"},  16'(blank),     16'h1);
        chk({tag, "_idx"},  16'(elem_idx),  16'h0);
        chk({tag, "_busy"}, 16'(busy),      16'h0);
    endtask

    initial begin
        rst = 1; load = 0; clear = 0; step = 0;
        auto_mode = 0; loop_en = 0; lz_blank = 0;
        ent = '{16'h1234, 16'h0020, 16'h0300, 16'h0004};
        set_data();
        tick(); tick();
        rst = 0;
        chk_idle("reset");

        // load, manual mode: scan two frames, index must not move
        load = 1; tick(); load = 0;
        chk("load_busy", 16'(busy), 16'h1);
        for (int k = 0; k < 40; k++) push_exp(k, 0, 0);
        for (int k = 0; k < 40; k++) begin pop_chk("scan0"); tick(); end

        // auto mode with wrap: advance every 32 cycles, scan uninterrupted
        auto_mode = 1; loop_en = 1;
        load = 1; tick(); load = 0;
        for (int k = 0; k < 136; k++) push_exp(k, (k / 32) % 4, 0);
        for (int k = 0; k < 136; k++) begin pop_chk("auto"); tick(); end

        // manual steps without wrap, ending in HOLD
        auto_mode = 0; loop_en = 0;
        load = 1; tick(); load = 0;
        repeat (50) tick();
        chk("nostep_idx", 16'(elem_idx), 16'h0);
        for (int s = 1; s <= 3; s++) begin
            step = 1; tick(); step = 0;
            chk("step_idx", 16'(elem_idx), 16'(s));
        end
        step = 1; tick(); step = 0;
        chk("hold_idx",  16'(elem_idx), 16'h3);
        chk("hold_busy", 16'(busy),     16'h1);
        loop_en = 1;
        step = 1; tick(); step = 0;
        chk("hold_step_idx", 16'(elem_idx), 16'h3);
        repeat (40) tick();
        chk("hold_dwell_idx", 16'(elem_idx), 16'h3);
        loop_en = 0;

        // leading-zero blanking on 0x0020
        lz_blank = 1;
        load = 1; tick(); load = 0;
        step = 1; tick(); step = 0;
        for (int k = 1; k < 17; k++) push_exp(k, 1, 1);
        for (int k = 1; k < 17; k++) begin pop_chk("lz20"); tick(); end

        // all-zero entry shows a single 0
        ent[0] = 16'h0000; set_data();
        load = 1; tick(); load = 0;
        for (int k = 0; k < 16; k++) push_exp(k, 0, 1);
        for (int k = 0; k < 16; k++) begin pop_chk("lz00"); tick(); end
        lz_blank = 0;

        // clear beats load and step
        clear = 1; load = 1; step = 1; tick();
        clear = 0; load = 0; step = 0;
        chk_idle("clr_prio");

        // load beats step at entry 2, new snapshot visible
        ent[0] = 16'h1234; set_data();
        load = 1; tick(); load = 0;
        step = 1; tick(); tick(); step = 0;
        chk("pre_ld_idx", 16'(elem_idx), 16'h2);
        ent = '{16'hbeef, 16'h5a5a, 16'h0300, 16'h0004}; set_data();
        load = 1; step = 1; tick(); load = 0; step = 0;
        push_exp(0, 0, 0);
        pop_chk("ld_prio");

        // reset mid-scan at entry 2, then step before load is ignored
        step = 1; tick(); tick(); step = 0;
        tick();
        chk("pre_rst_idx", 16'(elem_idx), 16'h2);
        rst = 1; tick(); rst = 0;
        chk_idle("mid_rst");
        step = 1; tick(); step = 0;
        chk_idle("rst_step");
        load = 1; tick(); load = 0;
        push_exp(0, 0, 0);
        pop_chk("reload");

        chk("sb_drained", 16'(sbq.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
